// File: rtl/sorted_drain_buffer_pkg.sv
// Shared defaults and the two-state controller encoding for the sorted drain buffer.
package sorted_drain_buffer_pkg;

  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/sort_buf_cell.sv
// One slot of the insertion-sort chain: holds a value and an occupied bit and
// decides locally whether to keep, load the new word, take its lower neighbour or its upper neighbour.
module sort_buf_cell
  import sorted_drain_buffer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             insert,
  input  logic             shift_down,
  input  logic [WIDTH-1:0] new_value,
  input  logic [WIDTH-1:0] prev_value,
  input  logic             prev_occupied,
  input  logic [WIDTH-1:0] next_value,
  input  logic             next_occupied,
  output logic [WIDTH-1:0] value,
  output logic             occupied
);

  logic here_candidate;
  logic prev_candidate;

  // A slot is a candidate when the new word belongs at or below it; strict
  // greater-than keeps equal values ahead of the newcomer.
  assign here_candidate = !occupied || (value > new_value);
  assign prev_candidate = !prev_occupied || (prev_value > new_value);

  always_ff @(posedge clk) begin
    if (rst) begin
      value    <= '0;
      occupied <= 1'b0;
    end else if (insert) begin
      if (here_candidate && !prev_candidate) begin
        value    <= new_value;
        occupied <= 1'b1;
      end else if (here_candidate) begin
        value    <= prev_value;
        occupied <= prev_occupied;
      end
    end else if (shift_down) begin
      value    <= next_value;
      occupied <= next_occupied;
    end
  end

endmodule

// File: rtl/sorted_drain_buffer.sv
// Batch buffer that sorts words ascending as they arrive, then drains them
// smallest first before accepting the next batch.
module sorted_drain_buffer
  import sorted_drain_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_last,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       truncated
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  state_t state;
  logic insert;
  logic shift_down;
  logic [WIDTH-1:0] cell_value [DEPTH];
  logic cell_occupied [DEPTH];

  assign in_ready   = !rst && (state == FILL) && (count < FULL_COUNT);
  assign insert     = in_valid && in_ready;
  assign shift_down = out_valid && out_ready;
  assign out_data   = cell_value[0];

  // Controller: FILL counts accepted words until in_last or full, DRAIN counts
  // handshakes down; out_last is precomputed so it is valid with its word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      count     <= '0;
      truncated <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (insert) begin
            count <= count + 1'b1;
            if (in_last || (count == LAST_SLOT)) begin
              state     <= DRAIN;
              out_valid <= 1'b1;
              out_last  <= (count == '0);
              truncated <= !in_last;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            count    <= count - 1'b1;
            out_last <= (count == CW'(2));
            if (out_last) begin
              state     <= FILL;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              truncated <= 1'b0;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [WIDTH-1:0] prev_value;
    logic             prev_occupied;
    logic [WIDTH-1:0] next_value;
    logic             next_occupied;

    // The head sees a phantom occupied neighbour that never outranks a new word.
    if (i == 0) begin : g_head
      assign prev_value    = '0;
      assign prev_occupied = 1'b1;
    end else begin : g_link_prev
      assign prev_value    = cell_value[i-1];
      assign prev_occupied = cell_occupied[i-1];
    end

    if (i == DEPTH - 1) begin : g_tail
      assign next_value    = '0;
      assign next_occupied = 1'b0;
    end else begin : g_link_next
      assign next_value    = cell_value[i+1];
      assign next_occupied = cell_occupied[i+1];
    end

    sort_buf_cell #(
      .WIDTH(WIDTH)
    ) u_cell (
      .clk          (clk),
      .rst          (rst),
      .insert       (insert),
      .shift_down   (shift_down),
      .new_value    (in_data),
      .prev_value   (prev_value),
      .prev_occupied(prev_occupied),
      .next_value   (next_value),
      .next_occupied(next_occupied),
      .value        (cell_value[i]),
      .occupied     (cell_occupied[i])
    );
  end

endmodule

// File: tb/tb_sorted_drain_buffer.sv
// Self-checking bench for sorted_drain_buffer: hand-derived vector table, directed
// batches and randomized batches scored against a queue-based reference model.
module tb_sorted_drain_buffer;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int CW = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic in_ready;
  logic out_valid;
  logic out_last;
  logic truncated;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0] count;

  sorted_drain_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .count    (count),
    .truncated(truncated)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the stored batch as an ascending queue plus two flags.
  int m_q[$];
  bit m_drain = 1'b0;
  bit m_trunc = 1'b0;
  int drained[$];

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       last;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic       e_ol;
    int         e_cnt;
    logic       e_tr;
  } vec_t;

  vec_t table_v[10];

  task automatic check_output(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic model_insert(input int v);
    int pos;
    pos = m_q.size();
    for (int k = 0; k < m_q.size(); k++) begin
      if (m_q[k] > v) begin
        pos = k;
        break;
      end
    end
    m_q.insert(pos, v);
  endtask

  // One clock: drive at the falling edge, check against the model, then advance the model at the rising edge.
  task automatic apply_stimulus(input logic iv, input logic [7:0] d, input logic last,
                                input logic ordy, input logic r);
    bit acc;
    @(negedge clk);
    rst = r;
    in_valid = iv;
    in_data = d;
    in_last = last;
    out_ready = ordy;
    #1;
    check_output("in_ready", int'(in_ready), int'(!r && !m_drain && (m_q.size() < DEPTH)));
    check_output("out_valid", int'(out_valid), int'(m_drain));
    check_output("out_last", int'(out_last), int'(m_drain && (m_q.size() == 1)));
    check_output("count", int'(count), m_q.size());
    check_output("truncated", int'(truncated), int'(m_trunc));
    if (m_drain) check_output("out_data", int'(out_data), m_q[0]);
    if (!r && out_valid && ordy) drained.push_back(int'(out_data));
    acc = !r && !m_drain && iv && (m_q.size() < DEPTH);
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_drain = 1'b0;
      m_trunc = 1'b0;
    end else if (acc) begin
      model_insert(int'(d));
      if (last) m_drain = 1'b1;
      else if (m_q.size() == DEPTH) begin
        m_drain = 1'b1;
        m_trunc = 1'b1;
      end
    end else if (m_drain && ordy) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        m_drain = 1'b0;
        m_trunc = 1'b0;
      end
    end
  endtask

  task automatic feed_values(input int vals[$]);
    for (int k = 0; k < vals.size(); k++)
      apply_stimulus(1'b1, 8'(vals[k]), 1'(k == vals.size() - 1), 1'b0, 1'b0);
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready
  task automatic drain_all(input int mode);
    logic ordy;
    for (int n = 0; n < 120 && m_drain; n++) begin
      case (mode)
        0: ordy = 1'b1;
        1: ordy = 1'((n % 3) == 0);
        default: ordy = 1'($urandom_range(0, 1));
      endcase
      apply_stimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), ordy, 1'b0);
    end
  endtask

  task automatic check_drained(input string tag, input int exp_q[$]);
    check_output({tag, "_len"}, drained.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < drained.size(); k++)
      check_output($sformatf("%s[%0d]", tag, k), drained[k], exp_q[k]);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int vals[$];
    int expq[$];
    int acc_vals[$];
    int len;
    int fed;
    logic iv;
    logic r;
    bit acc;

    //                 iv    d      last  ordy  ir    ov    od     ol    cnt tr
    table_v[0] = '{1'b1, 8'd0,  1'b1, 1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 0, 1'b0};
    table_v[1] = '{1'b1, 8'd55, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0,  1'b1, 1, 1'b0};
    table_v[2] = '{1'b0, 8'd0,  1'b0, 1'b1, 1'b0, 1'b1, 8'd0,  1'b1, 1, 1'b0};
    table_v[3] = '{1'b1, 8'd9,  1'b0, 1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 0, 1'b0};
    table_v[4] = '{1'b1, 8'd4,  1'b0, 1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1, 1'b0};
    table_v[5] = '{1'b1, 8'd9,  1'b1, 1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 2, 1'b0};
    table_v[6] = '{1'b0, 8'd0,  1'b0, 1'b1, 1'b0, 1'b1, 8'd4,  1'b0, 3, 1'b0};
    table_v[7] = '{1'b0, 8'd0,  1'b0, 1'b1, 1'b0, 1'b1, 8'd9,  1'b0, 2, 1'b0};
    table_v[8] = '{1'b0, 8'd0,  1'b0, 1'b1, 1'b0, 1'b1, 8'd9,  1'b1, 1, 1'b0};
    table_v[9] = '{1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 0, 1'b0};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    apply_stimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    check_output("reset_out_data", int'(out_data), 0);

    $display("[TB] vector table: single-word batch and tied three-word batch");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rst = 1'b0;
      in_valid = table_v[i].iv;
      in_data = table_v[i].d;
      in_last = table_v[i].last;
      out_ready = table_v[i].ordy;
      #1;
      check_output($sformatf("row%0d_in_ready", i), int'(in_ready), int'(table_v[i].e_ir));
      check_output($sformatf("row%0d_out_valid", i), int'(out_valid), int'(table_v[i].e_ov));
      check_output($sformatf("row%0d_out_last", i), int'(out_last), int'(table_v[i].e_ol));
      check_output($sformatf("row%0d_count", i), int'(count), table_v[i].e_cnt);
      check_output($sformatf("row%0d_truncated", i), int'(truncated), int'(table_v[i].e_tr));
      if (table_v[i].e_ov)
        check_output($sformatf("row%0d_out_data", i), int'(out_data), int'(table_v[i].e_od));
      @(posedge clk);
    end

    $display("[TB] ten-word batch");
    drained.delete();
    vals = '{42, 7, 99, 7, 1, 63, 100, 15, 88, 30};
    feed_values(vals);
    drain_all(0);
    expq = '{1, 7, 7, 15, 30, 42, 63, 88, 99, 100};
    check_drained("batch10", expq);

    $display("[TB] fifteen-word batch");
    drained.delete();
    vals = '{42, 7, 99, 7, 1, 63, 100, 15, 88, 30, 50, 2, 77, 2, 100};
    feed_values(vals);
    drain_all(0);
    expq = '{1, 2, 2, 7, 7, 15, 30, 42, 50, 63, 77, 88, 99, 100, 100};
    check_drained("batch15", expq);

    $display("[TB] seventeen words without last");
    drained.delete();
    acc_vals.delete();
    for (int k = 0; k < 17; k++) begin
      int v;
      v = $urandom_range(0, 255);
      if (k < DEPTH) acc_vals.push_back(v);
      apply_stimulus(1'b1, 8'(v), 1'b0, 1'b0, 1'b0);
    end
    drain_all(0);
    acc_vals.sort();
    check_drained("truncated16", acc_vals);

    $display("[TB] stalled drain");
    drained.delete();
    vals.delete();
    for (int k = 0; k < 8; k++) vals.push_back($urandom_range(0, 255));
    feed_values(vals);
    drain_all(1);
    vals.sort();
    check_drained("stalled", vals);

    $display("[TB] reset in the middle of a drain");
    vals = '{200, 3, 150, 3, 90, 17, 255, 64};
    feed_values(vals);
    for (int k = 0; k < 3; k++) apply_stimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    drained.delete();
    apply_stimulus(1'b1, 8'd5, 1'b1, 1'b0, 1'b0);
    drain_all(0);
    expq = '{5};
    check_drained("after_reset", expq);

    $display("[TB] randomized batches");
    for (int b = 0; b < 30; b++) begin
      len = $urandom_range(1, DEPTH + 1);
      fed = 0;
      for (int n = 0; n < 100 && !m_drain; n++) begin
        iv = 1'($urandom_range(0, 3) != 0);
        r = 1'($urandom_range(0, 59) == 0);
        acc = iv && !r && !m_drain && (m_q.size() < DEPTH);
        apply_stimulus(iv, 8'($urandom), 1'(fed == len - 1), 1'($urandom_range(0, 1)), r);
        if (r) fed = 0;
        else if (acc) fed++;
      end
      drain_all(2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
